// File: rtl/cpu_ctrl_param.sv
// cpu_ctrl_param: parameterised multi-cycle CPU controller.
// Holds the instruction register, decoder, an 8-state binary FSM, an 8-entry
// register file, the B-path shifter, the ALU and the N/V/Z status flags.
// Instructions enter through 'in' while the FSM waits in WAIT.
module cpu_ctrl_param #(
    parameter int DATA_W       = 16,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              err
);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_IMM = 3'd5,
        S_WR_REG = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;

    // Instruction fields, always taken from IR (stable outside WAIT).
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic [7:0] imm8;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign imm8   = ir[7:0];

    logic is_mov_imm, is_mov_reg, is_alu, is_add, is_cmp, is_and, is_mvn, legal;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_add     = is_alu && (op == 2'b00);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_and     = is_alu && (op == 2'b10);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign legal      = is_mov_imm || is_mov_reg || is_alu;

    logic [DATA_W-1:0] imm_ext;
    assign imm_ext = {{(DATA_W-8){imm8[7]}}, imm8};

    // B-path shifter: pass, LSL1, LSR1, ASR1.
    logic [DATA_W-1:0] sh_b;
    always_comb begin
        sh_b = b;
        case (sh)
            2'b01:   sh_b = {b[MSB-1:0], 1'b0};
            2'b10:   sh_b = {1'b0, b[MSB:1]};
            2'b11:   sh_b = {b[MSB], b[MSB:1]};
            default: sh_b = b;
        endcase
    end

    // ALU result for the C-writing ops; CMP uses diff directly.
    // MOV reg adds zero rather than the stale A register.
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] diff;
    logic              cmp_v;
    always_comb begin
        diff    = a - sh_b;
        alu_res = sh_b;
        if (is_add)
            alu_res = a + sh_b;
        else if (is_and)
            alu_res = a & sh_b;
        else if (is_mvn)
            alu_res = ~sh_b;
        cmp_v = (a[MSB] != sh_b[MSB]) && (diff[MSB] != a[MSB]);
    end

    // Instruction register: only captured while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir <= '0;
        else if (load && state == S_WAIT)
            ir <= in;
    end

    // Register file write port, driven by the two write-back states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                rf[i] <= '0;
        end else if (state == S_WR_REG) begin
            rf[rd] <= c;
        end else if (state == S_WR_IMM) begin
            rf[rn] <= imm_ext;
        end
    end

    // Control FSM with registered w/err and the A/B/C/flag datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            w     <= 1'b1;
            err   <= 1'b0;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            N     <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (s) begin
                        state <= S_DECODE;
                        w     <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_mov_imm)
                        state <= S_WR_IMM;
                    else if (is_mov_reg || is_mvn)
                        state <= S_GET_B;
                    else if (is_alu)
                        state <= S_GET_A;
                    else if (ILLEGAL_HALT) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end
                end
                S_GET_A: begin
                    a     <= rf[rn];
                    state <= S_GET_B;
                end
                S_GET_B: begin
                    b     <= rf[rm];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_cmp) begin
                        N     <= diff[MSB];
                        Z     <= (diff == '0);
                        V     <= cmp_v;
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end else begin
                        c     <= alu_res;
                        state <= S_WR_REG;
                    end
                end
                S_WR_REG, S_WR_IMM: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                    err   <= 1'b0;
                end
            endcase
            if (!legal && state == S_DECODE && !ILLEGAL_HALT)
                err <= 1'b0;
        end
    end

    assign out = c;

endmodule

// File: tb/tb_cpu_ctrl_param.sv
// Testbench for cpu_ctrl_param: three instances (16-bit halting, 16-bit NOP
// on illegal, 32-bit halting) driven with directed and random instructions,
// compared against an instruction-level reference model.
module tb_cpu_ctrl_param;
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        s_v = '0;
    logic [2:0]        load_v = '0;
    logic [2:0][15:0]  in_v = '0;
    logic [15:0]       out0, out1;
    logic [31:0]       out2;
    logic [2:0]        n_v, v_v, z_v, w_v, err_v;

    cpu_ctrl_param #(.DATA_W(16), .ILLEGAL_HALT(1'b1)) d0 (
        .clk(clk), .reset(reset), .s(s_v[0]), .load(load_v[0]), .in(in_v[0]),
        .out(out0), .N(n_v[0]), .V(v_v[0]), .Z(z_v[0]), .w(w_v[0]), .err(err_v[0]));
    cpu_ctrl_param #(.DATA_W(16), .ILLEGAL_HALT(1'b0)) d1 (
        .clk(clk), .reset(reset), .s(s_v[1]), .load(load_v[1]), .in(in_v[1]),
        .out(out1), .N(n_v[1]), .V(v_v[1]), .Z(z_v[1]), .w(w_v[1]), .err(err_v[1]));
    cpu_ctrl_param #(.DATA_W(32), .ILLEGAL_HALT(1'b1)) d2 (
        .clk(clk), .reset(reset), .s(s_v[2]), .load(load_v[2]), .in(in_v[2]),
        .out(out2), .N(n_v[2]), .V(v_v[2]), .Z(z_v[2]), .w(w_v[2]), .err(err_v[2]));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural state per instance.
    int          dw [3];
    logic [31:0] mr [3][8];
    logic [31:0] mc [3];
    bit          mn [3], mv [3], mz [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int k);
        case (k)
            0:       return {16'h0, out0};
            1:       return {16'h0, out1};
            default: return out2;
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++) mr[k][r] = '0;
            mc[k] = '0; mn[k] = 0; mv[k] = 0; mz[k] = 0;
        end
    endfunction

    function automatic longint to_signed(input logic [31:0] x, input int wd);
        if (((x >> (wd - 1)) & 32'h1) != 0)
            return longint'(x) - (longint'(1) << wd);
        return longint'(x);
    endfunction

    // Applies one instruction to the model; returns expected latency in edges.
    function automatic int model_exec(input int k, input logic [15:0] ins);
        int          wd   = dw[k];
        logic [31:0] mask = (wd == 32) ? 32'hFFFF_FFFF : ((32'h1 << wd) - 32'h1);
        logic [31:0] msb  = 32'h1 << (wd - 1);
        logic [2:0]  opc  = ins[15:13];
        logic [1:0]  op   = ins[12:11];
        logic [2:0]  rn   = ins[10:8];
        logic [2:0]  rd   = ins[7:5];
        logic [1:0]  sh   = ins[4:3];
        logic [2:0]  rm   = ins[2:0];
        logic [31:0] av, bv, sb, r;
        longint      d, lim;
        if (opc == 3'b110 && op == 2'b10) begin
            mr[k][rn] = {{24{ins[7]}}, ins[7:0]} & mask;
            return 3;
        end
        if (!(opc == 3'b101 || (opc == 3'b110 && op == 2'b00)))
            return 2;
        av = mr[k][rn];
        bv = mr[k][rm];
        case (sh)
            2'd0:    sb = bv;
            2'd1:    sb = (bv << 1) & mask;
            2'd2:    sb = bv >> 1;
            default: sb = (bv >> 1) | (bv & msb);
        endcase
        if (opc == 3'b110) begin
            mc[k] = sb; mr[k][rd] = sb; return 5;
        end
        case (op)
            2'd0: begin mc[k] = (av + sb) & mask; mr[k][rd] = mc[k]; return 6; end
            2'd1: begin
                r     = (av - sb) & mask;
                mn[k] = ((r >> (wd - 1)) & 32'h1) != 0;
                mz[k] = (r == 0);
                d     = to_signed(av, wd) - to_signed(sb, wd);
                lim   = longint'(1) << (wd - 1);
                mv[k] = (d >= lim) || (d < -lim);
                return 5;
            end
            2'd2: begin mc[k] = av & sb; mr[k][rd] = mc[k]; return 6; end
            default: begin mc[k] = (~sb) & mask; mr[k][rd] = mc[k]; return 5; end
        endcase
    endfunction

    // Issue one instruction on instance k and check latency, out and flags.
    // If dis > 0, load is pulsed with a junk word after edge 'dis'.
    task automatic run(input int k, input logic [15:0] ins, input int dis, input logic [15:0] junk);
        int n;
        int lat;
        @(negedge clk);
        in_v[k] = ins; load_v[k] = 1'b1; s_v[k] = 1'b1;
        @(posedge clk); n = 1; #1;
        load_v[k] = 1'b0; s_v[k] = 1'b0;
        while (w_v[k] !== 1'b1 && n < 20) begin
            if (n == dis) begin load_v[k] = 1'b1; in_v[k] = junk; end
            @(posedge clk); n++; #1;
            load_v[k] = 1'b0;
        end
        lat = model_exec(k, ins);
        chk($sformatf("lat%0d_%h", k, ins), 32'(n), 32'(lat));
        chk($sformatf("out%0d_%h", k, ins), get_out(k), mc[k]);
        chk($sformatf("N%0d_%h", k, ins), {31'h0, n_v[k]}, {31'h0, mn[k]});
        chk($sformatf("V%0d_%h", k, ins), {31'h0, v_v[k]}, {31'h0, mv[k]});
        chk($sformatf("Z%0d_%h", k, ins), {31'h0, z_v[k]}, {31'h0, mz[k]});
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] rand_legal();
        logic [15:0] x = 16'($urandom);
        case ($urandom_range(0, 5))
            0: x[15:11] = 5'b11010;
            1: begin x[15:11] = 5'b11000; x[10:8] = 3'($urandom); end
            default: x[15:13] = 3'b101;
        endcase
        return x;
    endfunction

    initial begin
        dw[0] = 16; dw[1] = 16; dw[2] = 32;
        model_reset();
        do_reset();
        #1;
        chk("rst_w", {31'h0, w_v[0]}, 32'h1);
        chk("rst_err", {31'h0, err_v[0]}, 32'h0);
        chk("rst_out", get_out(0), 32'h0);
        chk("rst_flags", {29'h0, n_v[0], v_v[0], z_v[0]}, 32'h0);

        // Directed 16-bit sequence
        run(0, 16'hD007, 0, 16'h0);
        run(0, 16'hD1FE, 0, 16'h0);
        run(0, 16'hA140, 0, 16'h0);
        chk("add_out", get_out(0), 32'h0005);
        run(0, 16'hD4FF, 0, 16'h0);
        run(0, 16'hC074, 0, 16'h0);
        chk("lsr_ffff", get_out(0), 32'h7FFF);
        run(0, 16'hAB04, 0, 16'h0);
        chk("cmp_ovf", {28'h0, get_out(0) == 32'h7FFF, n_v[0], v_v[0], z_v[0]}, 32'hE);
        run(0, 16'hA800, 0, 16'h0);
        chk("cmp_eq", {29'h0, n_v[0], v_v[0], z_v[0]}, 32'h1);
        run(0, 16'hC0B9, 0, 16'h0);
        chk("asr", get_out(0), 32'hFFFF);
        run(0, 16'hC0B1, 0, 16'h0);
        chk("lsr", get_out(0), 32'h7FFF);
        run(0, 16'hC0A8, 0, 16'h0);
        chk("lsl", get_out(0), 32'h000E);

        // Load during EXEC (after edge 4 of ADD) must not disturb IR
        run(0, 16'hA140, 4, 16'hD2AA);
        chk("ld_exec", get_out(0), 32'h0005);

        // Illegal-as-NOP on the second instance
        run(1, 16'hD107, 0, 16'h0);
        run(1, 16'hE000, 0, 16'h0);
        chk("nop_err", {31'h0, err_v[1]}, 32'h0);
        run(1, 16'hC001, 0, 16'h0);

        // 32-bit instance
        run(2, 16'hD080, 0, 16'h0);
        run(2, 16'hC060, 0, 16'h0);
        chk("sext32", get_out(2), 32'hFFFF_FF80);
        run(2, 16'hB820, 0, 16'h0);
        chk("mvn32", get_out(2), 32'h0000_007F);

        // Random phase: seed registers, then random instructions
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++)
                run(k, {5'b11010, 3'(r), 8'($urandom)}, 0, 16'h0);
            for (int i = 0; i < 30; i++) begin
                if (k == 1 && $urandom_range(0, 3) == 0)
                    run(k, 16'($urandom), 0, 16'h0);
                else
                    run(k, rand_legal(), 0, 16'h0);
            end
        end

        // Illegal halt: locks in ERR while s/load keep toggling in
        @(negedge clk);
        in_v[0] = 16'hE000; load_v[0] = 1'b1; s_v[0] = 1'b1;
        @(posedge clk); #1;
        in_v[0] = 16'hD007;
        @(posedge clk); #1;
        chk("err_set", {30'h0, err_v[0], w_v[0]}, 32'h2);
        repeat (20) @(posedge clk);
        #1;
        chk("err_hold", {30'h0, err_v[0], w_v[0]}, 32'h2);
        s_v[0] = 1'b0; load_v[0] = 1'b0;
        do_reset();
        #1;
        chk("err_clr", {30'h0, err_v[0], w_v[0]}, 32'h1);
        run(0, 16'hC0A7, 0, 16'h0);
        chk("rf_clr", get_out(0), 32'h0);

        // Asynchronous reset in EXEC of an ADD
        run(0, 16'hD007, 0, 16'h0);
        run(0, 16'hD1FE, 0, 16'h0);
        run(0, 16'hC041, 0, 16'h0);
        @(negedge clk);
        in_v[0] = 16'hA140; load_v[0] = 1'b1; s_v[0] = 1'b1;
        @(posedge clk); #1;
        load_v[0] = 1'b0; s_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_w", {31'h0, w_v[0]}, 32'h1);
        chk("arst_out", get_out(0), 32'h0);
        @(negedge clk); reset = 1'b0;
        model_reset();
        run(0, 16'hC042, 0, 16'h0);
        chk("arst_r2", get_out(0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
